// File: rtl/keypad_pkg.sv
// Shared keypad definitions: phase-counter width, emulator state encoding and
// the key-code to matrix-position table used by the emulator and scanner benches.
package keypad_pkg;

  localparam int unsigned CNT_W = 24;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'b0001,
    ST_BOUNCE = 4'b0010,
    ST_HOLD   = 4'b0100,
    ST_GAP    = 4'b1000
  } state_e;

  typedef struct packed {
    logic [1:0] col;
    logic [1:0] row;
  } key_pos_t;

  // Indexed by hex key code: column index driven low by the scanner, row bit pulled low.
  localparam key_pos_t KEY_MAP [16] = '{
    '{col: 2'd3, row: 2'd1},  // 0
    '{col: 2'd0, row: 2'd0},  // 1
    '{col: 2'd0, row: 2'd1},  // 2
    '{col: 2'd0, row: 2'd2},  // 3
    '{col: 2'd1, row: 2'd0},  // 4
    '{col: 2'd1, row: 2'd1},  // 5
    '{col: 2'd1, row: 2'd2},  // 6
    '{col: 2'd2, row: 2'd0},  // 7
    '{col: 2'd2, row: 2'd1},  // 8
    '{col: 2'd2, row: 2'd2},  // 9
    '{col: 2'd0, row: 2'd3},  // A
    '{col: 2'd1, row: 2'd3},  // B
    '{col: 2'd2, row: 2'd3},  // C
    '{col: 2'd3, row: 2'd3},  // D
    '{col: 2'd3, row: 2'd0},  // E
    '{col: 2'd3, row: 2'd2}   // F
  };

endpackage

// File: rtl/keypad_code2pos.sv
// Combinational decode of a hex key code into its keypad column and row index.
module keypad_code2pos
  import keypad_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [1:0] col_idx_o,
  output logic [1:0] row_idx_o
);

  key_pos_t pos;

  assign pos       = KEY_MAP[code_i];
  assign col_idx_o = pos.col;
  assign row_idx_o = pos.row;

endmodule

// File: rtl/keypad_emu.sv
// Matrix keypad emulator: presses one key per request with a bounce, hold and
// forced-release phase, answering the scanner's column drive on the row lines.
module keypad_emu
  import keypad_pkg::*;
#(
  parameter int unsigned BOUNCE_CYC = 16,
  parameter int unsigned HOLD_CYC   = 8_000_000,
  parameter int unsigned GAP_CYC    = 8_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  input  logic       press_valid,
  input  logic [3:0] press_key,
  output logic       press_ready,
  input  logic       cancel,
  output logic       busy,
  output logic       contact,
  output logic       done
);

  localparam logic [CNT_W-1:0] BOUNCE_LAST = CNT_W'((BOUNCE_CYC == 0) ? 0 : BOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tcol_q, tcol_d;
  logic [1:0]       trow_q, trow_d;
  logic [1:0]       dec_col, dec_row;
  logic             contact_q, contact_d;
  logic             done_q, done_d;
  logic             busy_q, ready_q;
  logic [3:0]       row_q, row_d;

  keypad_code2pos u_code2pos (
    .code_i    (press_key),
    .col_idx_o (dec_col),
    .row_idx_o (dec_row)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    tcol_d  = tcol_q;
    trow_d  = trow_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (press_valid && ready_q) begin
          tcol_d  = dec_col;
          trow_d  = dec_row;
          state_d = (BOUNCE_CYC == 0) ? ST_HOLD : ST_BOUNCE;
        end
      end
      ST_BOUNCE: begin
        if (cancel) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end else if (cnt_q == BOUNCE_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cancel || cnt_q == HOLD_LAST) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are derived from the next state so the registered copies line up
  // with state_q/cnt_q in the same cycle.
  assign contact_d = (state_d == ST_HOLD) || (state_d == ST_BOUNCE && cnt_d[2]);
  assign done_d    = (state_d == ST_GAP) && (cnt_d == GAP_LAST);

  always_comb begin
    row_d = 4'hF;
    if (contact_q && !col[tcol_q]) row_d[trow_q] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tcol_q    <= '0;
      trow_q    <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b1;
      row_q     <= 4'hF;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tcol_q    <= tcol_d;
      trow_q    <= trow_d;
      contact_q <= contact_d;
      done_q    <= done_d;
      busy_q    <= (state_d != ST_IDLE);
      ready_q   <= (state_d == ST_IDLE);
      row_q     <= row_d;
    end
  end

  assign row         = row_q;
  assign contact     = contact_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign press_ready = ready_q;

endmodule

// File: tb/tb_keypad_emu.sv
// Directed bench for keypad_emu: per-cycle scoreboard of row/contact/done/
// ready/busy against a phase model, plus a behavioural column scanner.
module tb_keypad_emu;

  localparam int B = 8;
  localparam int H = 20;
  localparam int G = 10;
  localparam int L = B + H + G;

  typedef struct packed {
    logic [3:0] row;
    logic       contact;
    logic       done;
    logic       ready;
    logic       busy;
  } obs_t;

  typedef struct {
    obs_t  exp;
    string tag;
  } sb_t;

  localparam obs_t IDLE_OBS = '{row: 4'hF, contact: 1'b0, done: 1'b0, ready: 1'b1, busy: 1'b0};

  // Physical layout: entry c*4+r is the key at column c, row bit r.
  localparam logic [3:0] LAYOUT [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };
  localparam logic [3:0] SWEEP [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] col, row, press_key;
  logic       press_valid, press_ready, cancel, busy, contact, done;

  int errors = 0;
  int checks = 0;
  sb_t sb_q[$];

  keypad_emu #(
    .BOUNCE_CYC (B),
    .HOLD_CYC   (H),
    .GAP_CYC    (G)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .col         (col),
    .row         (row),
    .press_valid (press_valid),
    .press_key   (press_key),
    .press_ready (press_ready),
    .cancel      (cancel),
    .busy        (busy),
    .contact     (contact),
    .done        (done)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    return '{row: row, contact: contact, done: done, ready: press_ready, busy: busy};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic key_pos(input logic [3:0] key, output int c, output int r);
    c = 0;
    r = 0;
    for (int i = 0; i < 16; i++)
      if (LAYOUT[i] == key) begin
        c = i / 4;
        r = i % 4;
      end
  endtask

  // Contact state in cycle j of a sequence whose hold phase lasts h cycles.
  function automatic logic m_contact(int j, int h);
    if (j < 0) return 1'b0;
    if (j < B) return j[2];
    if (j < B + h) return 1'b1;
    return 1'b0;
  endfunction

  function automatic obs_t m_obs(int j, int h, logic [3:0] prev_col, int tc, int tr);
    obs_t o;
    int   last;
    last      = B + h + G - 1;
    o.contact = m_contact(j, h);
    o.done    = (j == last);
    o.busy    = (j >= 0) && (j <= last);
    o.ready   = !o.busy;
    o.row     = 4'hF;
    if (m_contact(j - 1, h) && !prev_col[tc]) o.row[tr] = 1'b0;
    return o;
  endfunction

  // Request at cycle -1, then one scoreboard entry per cycle. hold_valid keeps
  // press_valid high so a second sequence starts right after the first.
  task automatic run_seq(input string name, input logic [3:0] key, input logic [3:0] col_static,
                         input bit sweep, input int cancel_at, input int gap_cancel_at,
                         input bit hold_valid, input int max_cyc);
    int         tc, tr, h, ncyc, jn, jr;
    logic [3:0] col_now;
    sb_t        s;
    key_pos(key, tc, tr);
    h    = (cancel_at >= 0) ? cancel_at - B + 1 : H;
    ncyc = hold_valid ? 2 * (L + 1) : B + h + G + 2;
    if (max_cyc > 0) ncyc = max_cyc;
    press_key   = key;
    press_valid = 1'b1;
    for (int j = -1; j < ncyc - 1; j++) begin
      col_now = sweep ? SWEEP[(j + 4) % 4] : col_static;
      col     = col_now;
      cancel  = (j == cancel_at) || (j == gap_cancel_at);
      if (hold_valid ? (j == L + 1) : (j == 0)) press_valid = 1'b0;
      jn = j + 1;
      jr = (hold_valid && jn >= L + 1) ? jn - (L + 1) : jn;
      sb_q.push_back('{m_obs(jr, h, col_now, tc, tr), $sformatf("%s cyc%0d", name, jn)});
      @(posedge clk);
      #1;
      s = sb_q.pop_front();
      check(s.tag, sample(), s.exp);
    end
    cancel      = 1'b0;
    press_valid = 1'b0;
  endtask

  // Scanner: walks one low column per cycle and decodes the first closed key seen.
  task automatic scan_key(input int k);
    logic [3:0] one, found;
    bit         seen;
    int         c;
    one         = 4'b0001;
    found       = 'x;
    seen        = 1'b0;
    press_key   = 4'(k);
    press_valid = 1'b1;
    for (int j = -1; j < L; j++) begin
      c   = (j + 4) % 4;
      col = ~(one << c);
      if (j == 0) press_valid = 1'b0;
      @(posedge clk);
      #1;
      if (!seen && row != 4'hF) begin
        seen = 1'b1;
        for (int r = 0; r < 4; r++)
          if (!row[r]) found = LAYOUT[c * 4 + r];
      end
    end
    check($sformatf("scan key %h", 4'(k)), {3'b000, seen, found}, {3'b000, 1'b1, 4'(k)});
  endtask

  initial begin
    rst_n       = 1'b0;
    col         = 4'hF;
    press_valid = 1'b0;
    press_key   = 4'h0;
    cancel      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset state", sample(), IDLE_OBS);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_seq("key5 static", 4'h5, 4'b1101, 1'b0, -1, -1, 1'b0, 0);
    run_seq("keyD sweep", 4'hD, 4'hF, 1'b1, -1, -1, 1'b0, 0);
    run_seq("key1 cancel", 4'h1, 4'b1110, 1'b0, B + 5, B + 6 + 3, 1'b0, 0);
    run_seq("key7 held valid", 4'h7, 4'b1011, 1'b0, -1, -1, 1'b1, 0);

    run_seq("keyF pre-reset", 4'hF, 4'b0000, 1'b0, -1, -1, 1'b0, 15);
    rst_n = 1'b0;
    #1;
    check("async reset in hold", sample(), IDLE_OBS);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < L + 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post-reset idle cyc%0d", i), sample(), IDLE_OBS);
    end

    for (int k = 0; k < 16; k++) scan_key(k);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_emu.md
KEYPAD_EMU -- requirements
Module: keypad_emu

Interface
REQ-001 Parameter BOUNCE_CYC, default 16: contact-bounce phase length in clk cycles; 0 skips the bounce phase.
REQ-002 Parameter HOLD_CYC, default 8_000_000: stable-contact phase length in clk cycles; legal range 1..2^24-1.
REQ-003 Parameter GAP_CYC, default 8_000_000: forced-release phase length in clk cycles; legal range 1..2^24-1.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 col  input  4  column drive from the scanner; active-low; col[i]=0 selects column i.
REQ-007 row  output  4  emulated row lines; active-low; a bit is 0 when a closed key connects it to a selected column.
REQ-008 press_valid  input  1  request to press the key on press_key.
REQ-009 press_key  input  4  hex key code to press.
REQ-010 press_ready  output  1  emulator can accept a request.
REQ-011 cancel  input  1  release the current key immediately.
REQ-012 busy  output  1  a press/release sequence is in progress.
REQ-013 contact  output  1  the key contact is currently closed.
REQ-014 done  output  1  one-cycle pulse at the end of each sequence.

Function
REQ-015 The key map SHALL be as follows, with col index given as the low bit position and row pattern as row[3:0]:
- col0: 1→row 1110, 2→1101, 3→1011, A→0111
- col1: 4, 5, 6, B
- col2: 7, 8, 9, C
- col3: E, 0, F, D
REQ-016 The FSM SHALL have the states IDLE, BOUNCE, HOLD and GAP, using one-hot encoding.
REQ-017 IDLE behaviour:
- press_ready=1, busy=0.
- On press_valid&press_ready, latch the decoded target col index and row index.
- Then go to BOUNCE, or to HOLD if BOUNCE_CYC=0.
REQ-018 BOUNCE SHALL last exactly BOUNCE_CYC cycles; contact=cnt[2] (toggles every 4 cycles, starting closed=0 at cnt=0); then go to HOLD.
REQ-019 HOLD SHALL last exactly HOLD_CYC cycles with contact=1, then go to GAP.
REQ-020 GAP SHALL last exactly GAP_CYC cycles with contact=0, then go to IDLE; done=1 on the GAP→IDLE transition cycle.
REQ-021 cancel=1 in BOUNCE or HOLD SHALL force GAP on the next cycle with the counter cleared; cancel in IDLE or GAP SHALL be ignored.
REQ-022 press_ready SHALL be 0 in every non-IDLE state; press_valid outside IDLE SHALL be ignored and not queued.
REQ-023 row SHALL be registered (1-cycle latency from col/contact), per cycle:
- row = 4'b1111 except bit target_row = 0 when contact=1 and col[target_col]=0.
- col=0000 therefore pulls the target row low while contact=1.
REQ-024 Only one row bit SHALL ever be 0; row SHALL be 1111 whenever contact=0.
REQ-025 The single phase counter SHALL be 24 bits, cleared on every state entry, and compared to the parameter minus 1 for exit.
REQ-026 A new request SHALL be acceptable in the cycle after done (IDLE re-entered); back-to-back sequences are allowed.

Reset
REQ-027 Asserting rst_n low SHALL force, asynchronously:
- state=IDLE, cnt=0, row=1111, contact=0, done=0, busy=0, press_ready=1.
- Latched target indices reset to 0.
REQ-028 Reset mid-sequence SHALL release the key immediately (row=1111) with no done pulse.

Structure
REQ-029 Key-map constants (code→col/row index table) and state encodings SHALL live in the shared package keypad_pkg, for reuse by the scanner testbench.
REQ-030 Key-code decode SHALL be a combinational sub-module keypad_code2pos (press_key → col index, row index); all other logic stays in keypad_emu.

Verification (BOUNCE_CYC=8, HOLD_CYC=20, GAP_CYC=10)
REQ-031 Press key 5, col=1101 static → row=1101 for exactly 20 cycles after the bounce phase, then 1111; done 10 cycles later.
REQ-032 Press key D while sweeping col 1110→1101→1011→0111 each cycle → row=0111 only one cycle after col=0111 is applied, otherwise 1111.
REQ-033 Press key 1, cancel asserted at HOLD cycle 5 → row=1111 the next cycle; GAP lasts 10 cycles; done=1 once.
REQ-034 press_valid held through the whole sequence with key 7 → exactly two back-to-back sequences; the second accepted the cycle after done.
REQ-035 rst_n pulsed low during HOLD with key F, col=0000 → row=1111 immediately; press_ready=1 and no done pulse.
REQ-036 Loop all 16 keys against a keypad scanner instance → scanner reports each matching key value.
